// File: rtl/upload_result_queue.sv
// upload_result_queue
//
// Buffers result descriptors (buffer address + byte count) from the PL pipeline and shows them
// one at a time to software through the register block. Software retires the descriptor on
// display by pulsing upload_result_next. After each retirement the enable stays low for a
// fixed gap, so software always sees a clean falling edge between descriptors.
//
// Optional feature: define UPLOAD_RESULT_TIMEOUT_EN to retire a descriptor automatically when
// it has been shown for TIMEOUT_CYCLES without an ack. Each such retirement is counted in
// drop_cnt. Without the macro, descriptors wait forever and drop_cnt is 0.
//
// Ports:
//   sys_clk, sys_rst        clock; synchronous active-high reset
//   push_valid/push_ready   producer handshake; push_addr / push_nbyte carry the descriptor
//   upload_result_en        a descriptor is on upload_result_addr / upload_result_nbyte
//   upload_result_next      one-cycle ack from software
//   queue_level             descriptors stored, not counting the one being shown
//   drop_cnt                saturating count of descriptors retired by timeout

module upload_result_queue #(
    parameter int unsigned DEPTH_LOG2     = 4,
    parameter int unsigned ADDR_BITWIDTH  = 32,
    parameter int unsigned NBYTE_BITWIDTH = 32,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      push_valid,
    output logic                      push_ready,
    input  logic [ADDR_BITWIDTH-1:0]  push_addr,
    input  logic [NBYTE_BITWIDTH-1:0] push_nbyte,
    output logic                      upload_result_en,
    output logic [31:0]               upload_result_addr,
    output logic [31:0]               upload_result_nbyte,
    input  logic                      upload_result_next,
    output logic [DEPTH_LOG2:0]       queue_level,
    output logic [15:0]               drop_cnt
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam int unsigned GapW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StPresent, StGap} state_e;

    state_e                    state_q, state_d;
    logic [DEPTH_LOG2-1:0]     wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]       count_q, count_d;
    logic [ADDR_BITWIDTH-1:0]  addr_q, addr_d;
    logic [NBYTE_BITWIDTH-1:0] nbyte_q, nbyte_d;
    logic [GapW-1:0]           gap_q, gap_d;

    logic [ADDR_BITWIDTH-1:0]  addr_mem_q  [Depth];
    logic [NBYTE_BITWIDTH-1:0] nbyte_mem_q [Depth];

    logic push_store;
    logic pop;
    logic expire;

    // Ready depends only on stored state: a same-cycle pop does not free a slot early.
    assign push_ready = (count_q < (DEPTH_LOG2 + 1)'(Depth));

    // Zero-length descriptors complete the handshake but are never stored.
    assign push_store = push_valid && push_ready && (push_nbyte != '0);
    assign pop        = (state_q == StIdle) && (count_q != '0);

`ifdef UPLOAD_RESULT_TIMEOUT_EN
    logic [31:0] to_cnt_q, to_cnt_d;
    logic [15:0] drop_q, drop_d;

    assign expire = (state_q == StPresent) && (to_cnt_q == TIMEOUT_CYCLES - 32'd1);

    always_comb begin
        // Held at zero outside PRESENT, so it starts from zero on every entry.
        to_cnt_d = (state_q == StPresent) ? to_cnt_q + 32'd1 : 32'd0;
        drop_d   = drop_q;
        // An ack on the expiry cycle is a normal retirement, not a drop.
        if (expire && !upload_result_next && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            to_cnt_q <= '0;
            drop_q   <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
            drop_q   <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`else
    logic unused_timeout;

    assign expire         = 1'b0;
    assign drop_cnt       = '0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_store) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_store, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        nbyte_d = nbyte_q;
        gap_d   = gap_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    addr_d  = addr_mem_q[rd_ptr_q];
                    nbyte_d = nbyte_mem_q[rd_ptr_q];
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (upload_result_next || expire) begin
                    addr_d  = '0;
                    nbyte_d = '0;
                    gap_d   = GapW'(GAP_CYCLES - 1);
                    state_d = StGap;
                end
            end
            StGap: begin
                if (gap_q == '0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            nbyte_q  <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            nbyte_q  <= nbyte_d;
            gap_q    <= gap_d;
        end
    end

    // Storage needs no reset: occupancy is defined entirely by the pointers and count.
    always_ff @(posedge sys_clk) begin
        if (push_store) begin
            addr_mem_q[wr_ptr_q]  <= push_addr;
            nbyte_mem_q[wr_ptr_q] <= push_nbyte;
        end
    end

    assign upload_result_en    = (state_q == StPresent);
    assign upload_result_addr  = 32'(addr_q);
    assign upload_result_nbyte = 32'(nbyte_q);
    assign queue_level         = count_q;

endmodule

// File: tb/tb_upload_result_queue.sv
// Self-checking bench for upload_result_queue: a vector table, directed corner sequences and
// a randomized run, all compared against a queue-based reference model.
// Define UPLOAD_RESULT_TIMEOUT_EN to also exercise the timeout feature (TIMEOUT_CYCLES = 16).

module tb_upload_result_queue;

    localparam int Depth = 16;
    localparam int Gap   = 2;
    localparam int To    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push_valid = 1'b0;
    logic        push_ready;
    logic [31:0] push_addr = '0;
    logic [31:0] push_nbyte = '0;
    logic        en;
    logic [31:0] raddr;
    logic [31:0] rnbyte;
    logic        next = 1'b0;
    logic [4:0]  level;
    logic [15:0] drop;

    always #5 clk = ~clk;

    upload_result_queue #(
        .DEPTH_LOG2    (4),
        .ADDR_BITWIDTH (32),
        .NBYTE_BITWIDTH(32),
        .GAP_CYCLES    (Gap),
        .TIMEOUT_CYCLES(32'd16)
    ) dut (
        .sys_clk            (clk),
        .sys_rst            (rst),
        .push_valid         (push_valid),
        .push_ready         (push_ready),
        .push_addr          (push_addr),
        .push_nbyte         (push_nbyte),
        .upload_result_en   (en),
        .upload_result_addr (raddr),
        .upload_result_nbyte(rnbyte),
        .upload_result_next (next),
        .queue_level        (level),
        .drop_cnt           (drop)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored descriptors, the one on display, and the earliest
    // clock edge at which the next descriptor may be taken for display.
    logic [31:0] mq_addr[$];
    logic [31:0] mq_nbyte[$];
    bit          m_shown;
    logic [31:0] m_addr;
    logic [31:0] m_nbyte;
    int          m_edge = 0;
    int          m_next_pop = 0;
    int          m_start = 0;
    int          m_drop = 0;

    task automatic model_edge();
        bit ready, pop, ack, expire;
        if (rst) begin
            mq_addr.delete();
            mq_nbyte.delete();
            m_shown    = 0;
            m_addr     = '0;
            m_nbyte    = '0;
            m_next_pop = 0;
            m_drop     = 0;
            m_edge++;
            return;
        end
        ready  = mq_addr.size() < Depth;
        pop    = !m_shown && (m_edge >= m_next_pop) && (mq_addr.size() > 0);
        ack    = m_shown && next;
`ifdef UPLOAD_RESULT_TIMEOUT_EN
        expire = m_shown && !ack && ((m_edge - m_start) == To - 1);
`else
        expire = 0;
`endif
        if (ack || expire) begin
            m_shown    = 0;
            // en low for Gap cycles, then one idle cycle in which the next pop happens
            m_next_pop = m_edge + 1 + Gap;
            if (expire && m_drop < 65535) m_drop++;
        end
        if (pop) begin
            m_addr  = mq_addr.pop_front();
            m_nbyte = mq_nbyte.pop_front();
            m_shown = 1;
            m_start = m_edge + 1;
        end
        if (push_valid && ready && push_nbyte != 0) begin
            mq_addr.push_back(push_addr);
            mq_nbyte.push_back(push_nbyte);
        end
        m_edge++;
    endtask

    task automatic compare_all();
        check("model_en", en, m_shown);
        check("model_addr", raddr, m_shown ? m_addr : 32'h0);
        check("model_nbyte", rnbyte, m_shown ? m_nbyte : 32'h0);
        check("model_level", level, mq_addr.size());
        check("model_ready", push_ready, mq_addr.size() < Depth);
        check("model_drop", drop, m_drop);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        push_valid = 1'b0;
        next       = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_en(input string name);
        for (int i = 0; i < 20 && !en; i++) step();
        check(name, en, 1'b1);
    endtask

    typedef struct {
        bit          valid;
        logic [31:0] addr;
        logic [31:0] nbyte;
        bit          nxt;
        bit          exp_en;
        logic [31:0] exp_addr;
        logic [31:0] exp_nbyte;
        int          exp_level;
    } vec_t;

    vec_t tv[6];

    initial begin
        int max_level;
        int n_high;
        bit seen_other;

        tv[0] = '{1, 32'h1000_0000, 32'h400, 0, 0, 32'h0, 32'h0, 1};
        tv[1] = '{0, 32'h0, 32'h0, 0, 1, 32'h1000_0000, 32'h400, 0};
        tv[2] = '{0, 32'h0, 32'h0, 0, 1, 32'h1000_0000, 32'h400, 0};
        tv[3] = '{0, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0, 0};
        tv[4] = '{0, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0, 0};
        tv[5] = '{0, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0, 0};

        // Reset state
        do_reset();
        check("rst_en", en, 1'b0);
        check("rst_level", level, 0);
        check("rst_ready", push_ready, 1'b1);
        check("rst_drop", drop, 0);

        // Single push, ack, gap, and acks outside PRESENT
        for (int i = 0; i < 6; i++) begin
            push_valid = tv[i].valid;
            push_addr  = tv[i].addr;
            push_nbyte = tv[i].nbyte;
            next       = tv[i].nxt;
            step();
            check("vec_en", en, tv[i].exp_en);
            check("vec_addr", raddr, tv[i].exp_addr);
            check("vec_nbyte", rnbyte, tv[i].exp_nbyte);
            check("vec_level", level, tv[i].exp_level);
        end
        next = 1'b0;

        // Three pushes, acks ten cycles after each presentation
        do_reset();
        for (int k = 0; k < 3; k++) begin
            push_valid = 1'b1;
            push_addr  = 32'h3000_0000 + k;
            push_nbyte = 32'h10 * (k + 1);
            step();
        end
        push_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_en("order_wait_en");
            check("order_addr", raddr, 32'h3000_0000 + k);
            check("order_nbyte", rnbyte, 32'h10 * (k + 1));
            for (int i = 0; i < 9; i++) step();
            next = 1'b1;
            step();
            next = 1'b0;
            for (int i = 0; i < Gap + 1; i++) begin
                check("gap_low", en, 1'b0);
                step();
            end
            if (k < 2) check("gap_next_shown", en, 1'b1);
            else check("gap_empty_low", en, 1'b0);
        end

        // Fill the queue: 17 pushes, the 18th stalls until a pop frees a slot
        do_reset();
        for (int i = 0; i < 17; i++) begin
            push_valid = 1'b1;
            push_addr  = 32'h2000_0000 + i;
            push_nbyte = i + 1;
            check("fill_ready", push_ready, 1'b1);
            step();
        end
        check("fill_level", level, 16);
        check("fill_en", en, 1'b1);
        check("fill_head", raddr, 32'h2000_0000);
        push_addr  = 32'h2000_0011;
        push_nbyte = 32'h12;
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", push_ready, 1'b0);
            step();
        end
        check("stall_level", level, 16);
        next = 1'b1;
        step();
        next = 1'b0;
        for (int i = 0; i < 10 && !push_ready; i++) step();
        check("stall_release", push_ready, 1'b1);
        check("stall_release_level", level, 15);
        step();
        push_valid = 1'b0;
        check("stall_accepted", level, 16);

        // Zero-length descriptor is dropped
        do_reset();
        push_valid = 1'b1;
        push_addr  = 32'hDEAD_0000;
        push_nbyte = 32'h0;
        step();
        check("zero_level", level, 0);
        push_addr  = 32'hBEEF_0000;
        push_nbyte = 32'h8;
        step();
        push_valid = 1'b0;
        max_level  = level;
        seen_other = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (level > max_level) max_level = level;
            if (en && raddr != 32'hBEEF_0000) seen_other = 1;
        end
        check("zero_max_level", max_level <= 1, 1'b1);
        check("zero_only_eight", seen_other, 1'b0);
        check("zero_shown", rnbyte, 32'h8);

        // Reset while presenting with five queued
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_valid = 1'b1;
            push_addr  = 32'h4000_0000 + i;
            push_nbyte = 32'h20;
            step();
        end
        push_valid = 1'b0;
        step();
        check("mid_pre_en", en, 1'b1);
        check("mid_pre_level", level, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_en", en, 1'b0);
        check("mid_level", level, 0);
        check("mid_ready", push_ready, 1'b1);

`ifdef UPLOAD_RESULT_TIMEOUT_EN
        // Timeout with no ack
        do_reset();
        push_valid = 1'b1;
        push_addr  = 32'h5000_0000;
        push_nbyte = 32'h44;
        step();
        push_valid = 1'b0;
        wait_en("to_wait_en");
        n_high = 1;
        for (int i = 0; i < 40 && en; i++) begin
            step();
            if (en) n_high++;
        end
        check("to_high_cycles", n_high, To);
        check("to_drop", drop, 1);

        // Ack on the expiry cycle is not a drop
        push_valid = 1'b1;
        push_addr  = 32'h5000_0001;
        step();
        push_valid = 1'b0;
        wait_en("to_ack_wait_en");
        for (int i = 0; i < To - 1; i++) step();
        check("to_ack_still_en", en, 1'b1);
        next = 1'b1;
        step();
        next = 1'b0;
        check("to_ack_en", en, 1'b0);
        check("to_ack_drop", drop, 1);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 999) == 0);
            push_valid = $urandom_range(0, 1);
            push_addr  = $urandom;
            push_nbyte = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            next       = ($urandom_range(0, 4) == 0);
            step();
        end
        rst        = 1'b0;
        push_valid = 1'b0;
        next       = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
